// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with ALU control decode, forwarding and operand select
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [1:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_dest,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_dest,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [3:0]        ex_alu_ctl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_valid,
    output logic              ex_illegal,
    output logic              load_use_hazard
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        alu_ctl;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              illegal;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } idex_t;

    idex_t idex_q;
    idex_t idex_d;

    logic [3:0] dec_ctl;
    logic       dec_illegal;
    logic       zero_ext;

    always_comb begin
        dec_ctl     = 4'b1111;
        dec_illegal = 1'b0;
        unique case (id_alu_op)
            2'b00: dec_ctl = 4'b0010;
            2'b01: dec_ctl = 4'b0110;
            2'b10: begin
                case (id_funct)
                    6'b100000: dec_ctl = 4'b0010;
                    6'b100010: dec_ctl = 4'b0110;
                    6'b100100: dec_ctl = 4'b0000;
                    6'b100101: dec_ctl = 4'b0001;
                    6'b101010: dec_ctl = 4'b0111;
                    6'b100111: dec_ctl = 4'b1100;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (id_opcode)
                    6'b001000: dec_ctl = 4'b0010;
                    6'b001100: dec_ctl = 4'b0000;
                    6'b001101: dec_ctl = 4'b0001;
                    6'b001010: dec_ctl = 4'b0111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Logical immediates (andi/ori) zero-extend; everything else sign-extends.
    assign zero_ext = (id_alu_op == 2'b11) &&
                      ((id_opcode == 6'b001100) || (id_opcode == 6'b001101));

    always_comb begin
        idex_d           = '0;
        idex_d.valid     = id_valid;
        idex_d.alu_ctl   = dec_ctl;
        idex_d.alu_src   = id_alu_src;
        idex_d.reg_write = id_reg_write & id_valid & ~dec_illegal;
        idex_d.mem_read  = id_mem_read  & id_valid & ~dec_illegal;
        idex_d.mem_write = id_mem_write & id_valid & ~dec_illegal;
        idex_d.illegal   = dec_illegal  & id_valid;
        idex_d.rs        = id_rs;
        idex_d.rt        = id_rt;
        idex_d.dest      = id_dest;
        idex_d.rs_data   = id_rs_data;
        idex_d.rt_data   = id_rt_data;
        idex_d.imm       = zero_ext ? {{(DATA_W-16){1'b0}}, id_imm}
                                    : {{(DATA_W-16){id_imm[15]}}, id_imm};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            idex_q <= '0;
        end else if (!stall) begin
            idex_q <= idex_d;
        end
    end

    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] r,
                                              input logic [DATA_W-1:0] rf_data);
        if (exm_reg_write && exm_dest != '0 && exm_dest == r)
            return exm_result;
        else if (mwb_reg_write && mwb_dest != '0 && mwb_dest == r)
            return mwb_result;
        else
            return rf_data;
    endfunction

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    assign fwd_rs        = fwd(idex_q.rs, idex_q.rs_data);
    assign fwd_rt        = fwd(idex_q.rt, idex_q.rt_data);
    assign ex_a          = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign ex_b          = idex_q.alu_src ? idex_q.imm : fwd_rt;

    assign ex_alu_ctl    = idex_q.alu_ctl;
    assign ex_dest       = idex_q.dest;
    assign ex_reg_write  = idex_q.reg_write;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_valid      = idex_q.valid;
    assign ex_illegal    = idex_q.illegal;

    assign load_use_hazard = idex_q.valid && idex_q.mem_read && (idex_q.dest != '0) &&
                             id_valid && ((idex_q.dest == id_rs) || (idex_q.dest == id_rt));

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_dest, mwb_dest;
    logic [31:0] exm_result, mwb_result;
    logic [3:0]  ex_alu_ctl;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, ex_illegal;
    logic        load_use_hazard;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_dest(mwb_dest), .mwb_result(mwb_result),
        .ex_alu_ctl(ex_alu_ctl), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_valid(ex_valid), .ex_illegal(ex_illegal),
        .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] funct_tab [6];
    logic [3:0] ctl_tab   [6];

    initial begin
        funct_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        ctl_tab   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

        rst_n = 0; stall = 1; flush = 0; id_valid = 1;
        id_opcode = 0; id_funct = 6'b100000; id_alu_op = 2'b10; id_alu_src = 0;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
        id_rs = 1; id_rt = 2; id_dest = 3;
        id_rs_data = 32'h0000_00F0; id_rt_data = 32'h0000_000F; id_imm = 0;
        exm_reg_write = 0; exm_dest = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_dest = 0; mwb_result = 0;

        // reset with stall asserted
        tick(); tick();
        chk("rst_ctl", 32'(ex_alu_ctl), 32'h0);
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_a", ex_a, 32'h0);
        chk("rst_b", ex_b, 32'h0);
        chk("rst_store", ex_store_data, 32'h0);
        chk("rst_rw", 32'(ex_reg_write), 32'h0);
        chk("rst_hazard", 32'(load_use_hazard), 32'h0);

        rst_n = 1; stall = 0;
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'h1);
        chk("post_rst_ctl", 32'(ex_alu_ctl), 32'h2);

        // R-type decode
        for (int i = 0; i < 6; i++) begin
            id_funct = funct_tab[i];
            tick();
            chk($sformatf("rtype_ctl%0d", i), 32'(ex_alu_ctl), 32'(ctl_tab[i]));
            chk($sformatf("rtype_a%0d", i), ex_a, 32'h0000_00F0);
            chk($sformatf("rtype_b%0d", i), ex_b, 32'h0000_000F);
            chk($sformatf("rtype_rw%0d", i), 32'(ex_reg_write), 32'h1);
        end
        id_funct = 6'b000000;
        tick();
        chk("illegal_ctl", 32'(ex_alu_ctl), 32'hF);
        chk("illegal_flag", 32'(ex_illegal), 32'h1);
        chk("illegal_rw", 32'(ex_reg_write), 32'h0);

        // immediates
        id_alu_op = 2'b11; id_opcode = 6'b001000; id_imm = 16'hFFFC; id_alu_src = 1;
        tick();
        chk("addi_b", ex_b, 32'hFFFF_FFFC);
        chk("addi_ctl", 32'(ex_alu_ctl), 32'h2);
        chk("addi_illegal", 32'(ex_illegal), 32'h0);
        id_opcode = 6'b001101; id_imm = 16'h8000;
        tick();
        chk("ori_b", ex_b, 32'h0000_8000);
        chk("ori_ctl", 32'(ex_alu_ctl), 32'h1);
        id_alu_op = 2'b00;
        tick();
        chk("lw_imm_sext", ex_b, 32'hFFFF_8000);
        chk("lw_ctl", 32'(ex_alu_ctl), 32'h2);

        // forwarding
        id_alu_op = 2'b10; id_funct = 6'b100000; id_alu_src = 0;
        id_rs = 5; id_rt = 6;
        tick();
        exm_reg_write = 1; exm_dest = 5; exm_result = 32'hAAAA_AAAA;
        mwb_reg_write = 1; mwb_dest = 5; mwb_result = 32'h5555_5555;
        #1;
        chk("fwd_exm_wins", ex_a, 32'hAAAA_AAAA);
        chk("fwd_rt_none", ex_b, 32'h0000_000F);
        exm_reg_write = 0;
        #1;
        chk("fwd_mwb", ex_a, 32'h5555_5555);
        mwb_dest = 6;
        #1;
        chk("fwd_store_mwb", ex_store_data, 32'h5555_5555);
        chk("fwd_b_mwb", ex_b, 32'h5555_5555);
        id_rs = 0;
        tick();
        exm_reg_write = 1; exm_dest = 0; mwb_reg_write = 1; mwb_dest = 0;
        #1;
        chk("fwd_r0_none", ex_a, 32'h0000_00F0);
        exm_reg_write = 0; mwb_reg_write = 0;

        // load-use hazard
        id_alu_op = 2'b00; id_alu_src = 1; id_mem_read = 1; id_reg_write = 1;
        id_dest = 8; id_rs = 1; id_rt = 2;
        tick();
        chk("lw_mem_read", 32'(ex_mem_read), 32'h1);
        id_alu_op = 2'b10; id_alu_src = 0; id_mem_read = 0; id_rs = 9; id_rt = 8; id_dest = 10;
        #1;
        chk("hazard_set", 32'(load_use_hazard), 32'h1);
        id_valid = 0;
        #1;
        chk("hazard_idvalid0", 32'(load_use_hazard), 32'h0);
        id_valid = 1;
        stall = 1; flush = 1;
        tick();
        chk("bubble_valid", 32'(ex_valid), 32'h0);
        chk("bubble_rw", 32'(ex_reg_write), 32'h0);
        chk("bubble_mr", 32'(ex_mem_read), 32'h0);
        chk("bubble_mw", 32'(ex_mem_write), 32'h0);
        chk("bubble_hazard", 32'(load_use_hazard), 32'h0);
        stall = 0; flush = 0;

        // stall hold
        id_funct = 6'b100010; id_rs = 5; id_rt = 6; id_dest = 7;
        id_rs_data = 32'h100; id_rt_data = 32'h200;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_funct = 6'b100000; id_dest = 5'(11 + i); id_rs_data = 32'(i * 7 + 1);
            tick();
            chk($sformatf("stall_ctl%0d", i), 32'(ex_alu_ctl), 32'h6);
            chk($sformatf("stall_dest%0d", i), 32'(ex_dest), 32'h7);
            chk($sformatf("stall_a%0d", i), ex_a, 32'h100);
            chk($sformatf("stall_b%0d", i), ex_b, 32'h200);
        end
        exm_reg_write = 1; exm_dest = 5; exm_result = 32'h1234_5678;
        #1;
        chk("stall_fwd", ex_a, 32'h1234_5678);
        exm_reg_write = 0;

        // reset mid-stream discards the held instruction
        rst_n = 0;
        tick();
        chk("midrst_valid", 32'(ex_valid), 32'h0);
        chk("midrst_a", ex_a, 32'h0);
        chk("midrst_ctl", 32'(ex_alu_ctl), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand preparation for the MIPS datapath.
- Captures decoded instruction fields every cycle and decodes ALUOp/funct/opcode into the 4-bit ALU control code.
- Applies EX/MEM and MEM/WB forwarding, selects register or immediate for operand B, and drives A, B and ALU_Ctl straight into the ALU.
- Also flags load-use hazards to the hazard unit.

Parameters:
DATA_W, 32, datapath/operand width
REG_AW, 5, register-file address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold ID/EX register contents
flush  in  1  load a bubble into ID/EX
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  6  instruction[31:26]
id_funct  in  6  instruction[5:0]
id_alu_op  in  2  main-control ALUOp
id_alu_src  in  1  1 = operand B from immediate
id_reg_write, id_mem_read, id_mem_write  in  1 each  main-control bits
id_rs, id_rt, id_dest  in  REG_AW  source/destination register numbers
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  16  instruction[15:0]
exm_reg_write  in  1;  exm_dest  in  REG_AW;  exm_result  in  DATA_W  EX/MEM forward source
mwb_reg_write  in  1;  mwb_dest  in  REG_AW;  mwb_result  in  DATA_W  MEM/WB forward source
ex_alu_ctl  out  4  ALU control code
ex_a, ex_b  out  DATA_W  ALU operands
ex_store_data  out  DATA_W  forwarded rt for stores
ex_dest  out  REG_AW;  ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, ex_illegal  out  1 each
load_use_hazard  out  1  combinational hazard flag to the hazard unit

Behaviour:
- Reset (rst_n=0 at a clk edge): all ID/EX register fields = 0, including valid, control, dest, data, imm and alu_ctl (4'b0000).
  - Consequences: ex_a = ex_b = ex_store_data = 0 unless a forward hits; load_use_hazard = 0.
  - Reset overrides stall and flush.
  - Reset mid-stream discards the held instruction.
- Update priority per edge: reset > flush > stall > load.
  - flush: loads a bubble (all fields 0). Flush with stall asserted also loads a bubble.
  - stall: holds every field unchanged.
  - load: captures the decoded ID values.
- Control gating: reg_write, mem_read, mem_write and illegal are captured ANDed with id_valid, so a bubble never writes or accesses memory.
- ALU_Ctl decode, registered with the other fields (1-cycle latency ID->EX):
  - ALUOp 00 -> 0010 (add; lw/sw).
  - ALUOp 01 -> 0110 (sub; beq).
  - ALUOp 10, by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
  - ALUOp 11, by opcode: 001000 addi -> 0010, 001100 andi -> 0000, 001101 ori -> 0001, 001010 slti -> 0111.
  - Any other funct/opcode -> ctl 1111, illegal = 1 (registered with the instruction), reg_write and mem_* forced 0.
- Immediate, registered as a 32-bit value:
  - zero-extended for andi/ori (ALUOp 11 with opcode 001100/001101);
  - sign-extended in all other cases.
- Forwarding, combinational on the registered rs/rt, applied independently to rs and rt:
  - EX/MEM hit: exm_reg_write & exm_dest != 0 & exm_dest == reg.
  - MEM/WB hit: mwb_reg_write & mwb_dest != 0 & mwb_dest == reg.
  - EX/MEM wins when both hit. Register 0 is never forwarded.
- Operand outputs:
  - ex_a = forwarded rs.
  - ex_store_data = forwarded rt.
  - ex_b = immediate when alu_src = 1, else forwarded rt.
- load_use_hazard = ex_valid & ex_mem_read & ex_dest != 0 & id_valid & (ex_dest == id_rs | ex_dest == id_rt).
  - The hazard unit responds by stalling IF/ID and asserting flush here, giving exactly one bubble.
- No arithmetic is performed here; widths are passed through unchanged.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with stall=1 and id_valid=1 -> all outputs 0, ex_alu_ctl=0000, ex_valid=0; first edge after release captures ID normally.
- R-type decode: ALUOp=10 with each funct (add/sub/and/or/slt/nor), rs_data=32'h0000_00F0, rt_data=32'h0000_000F -> next cycle ctl 0010/0110/0000/0001/0111/1100, ex_a=F0, ex_b=0F; funct 000000 -> ctl 1111, illegal=1, reg_write=0.
- Immediate: addi imm=16'hFFFC -> ex_b=32'hFFFF_FFFC, ctl 0010; ori imm=16'h8000 -> ex_b=32'h0000_8000, ctl 0001.
- Forwarding: ID/EX rs=5, exm_dest=5 with exm_result=32'hAAAA_AAAA, mwb_dest=5 with mwb_result=32'h5555_5555, both write -> ex_a=AAAA_AAAA; drop exm_reg_write -> 5555_5555; rs=0 with dests 0 -> no forward.
- Load-use: lw to r8 in EX, ID instruction reads rt=8 -> load_use_hazard=1; apply stall=1 + flush=1 -> bubble (ex_valid=0, all writes 0); next cycle hazard=0.
- Stall hold: load sub, then stall=1 for 3 cycles while ID inputs change -> ex_alu_ctl=0110 and all fields unchanged; forwarding still tracks exm/mwb changes.
